spi_bram_bridge: RTL
====================

SPI_BRAM_BRIDGE -- requirements
Module: spi_bram_bridge

Parameters
REQ-001 SHALL have parameter ADDR_W, default 17, the BRAM word address width.
REQ-002 SHALL have parameter DEPTH, default 76800, the words per channel (DEPTH <= 2**ADDR_W).
REQ-003 SHALL have parameter NUM_CH, default 3, the number of image channels.
REQ-004 SHALL have parameter CH_W, default 2, the channel select width (CH_W <= 6).

Interface
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port spi_ss, input, 1 bit: SPI select, active-low, synchronised to clk.
REQ-008 SHALL have port spi_done, input, 1 bit: one-cycle pulse per completed SPI byte.
REQ-009 SHALL have port spi_rx, input, 8 bits: received byte, valid with spi_done.
REQ-010 SHALL have port spi_tx, output, 8 bits: byte the SPI slave shifts out on the next transfer.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: BRAM address.
REQ-012 SHALL have port mem_channel, output, CH_W bits: BRAM channel select.
REQ-013 SHALL have port mem_we, output, 1 bit: BRAM write enable, one-cycle pulse.
REQ-014 SHALL have port mem_wdata, output, 8 bits: BRAM write data.
REQ-015 SHALL have port mem_rdata, input, 8 bits: BRAM read data, valid 1 cycle after mem_addr.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 SHALL have port err, output, 1 bit: sticky protocol error flag.
REQ-018 SHALL have port state, output, 3 bits: FSM state code.

Function
REQ-019 SHALL encode states as IDLE=0, ADDR=1, LEN=2, WDATA=3, RDATA=4, STAT=5.
REQ-020 SHALL decode the first byte after spi_ss falls as a command: op=cmd[7:6] (00 NOP, 01 WRITE, 10 READ, 11 STATUS), channel=cmd[CH_W-1:0].
REQ-021 SHALL, for WRITE/READ, take AB=ceil(ADDR_W/8) address bytes MSB-first (upper unused bits ignored), then 2 length bytes MSB-first; transfer count = LEN+1 (1..65536).
REQ-022 SHALL, when channel >= NUM_CH or start address >= DEPTH, set err and return to IDLE without any mem_we (channel checked at command byte, address after the last address byte).
REQ-023 SHALL, in WDATA, issue one mem_we pulse per spi_done, exactly 1 cycle after it, with mem_wdata=spi_rx and the current address.
REQ-024 SHALL increment the address after each data byte, wrapping from DEPTH-1 to 0.
REQ-025 SHALL, for READ, drive the start address on the cycle after the last LEN byte and load mem_rdata into spi_tx within 2 cycles, before the next SPI byte begins.
REQ-026 SHALL, in RDATA, on each spi_done advance the address, prefetch, and reload spi_tx within 2 cycles; received bytes are ignored.
REQ-027 SHALL return to IDLE after the (LEN+1)th data byte; spi_tx=0x00 in IDLE.
REQ-028 SHALL, on STATUS, load spi_tx={err,1'b0,CH_W-bit-agnostic 3'b0,NUM_CH[2:0]}, go to STAT, clear err on the next spi_done, then return to IDLE.
REQ-029 SHALL, on spi_ss rising in any state, abort to IDLE next cycle, with no further mem_we and already-written bytes kept.
REQ-030 SHALL, when spi_done coincides with spi_ss rising, discard the byte (abort wins).
REQ-031 SHALL treat NOP as a single-byte command that leaves the FSM in IDLE.
REQ-032 SHALL drive mem_channel as a registered value held for the whole transfer.

Reset
REQ-033 SHALL, on rst high at a clk edge, set state=IDLE, busy=0, err=0, mem_we=0, mem_addr=0, mem_channel=0, mem_wdata=0, spi_tx=0x00, counters=0.
REQ-034 SHALL, when rst is asserted mid-transfer, abort with no mem_we pulse on or after the reset cycle.

Verification
REQ-035 SHALL cover: WRITE ch1 addr 0x00010 LEN 3, data A0..A3 -> 4 mem_we pulses, addr 0x10..0x13, channel 1.
REQ-036 SHALL cover: READ ch1 addr 0x00010 LEN 3 -> MISO bytes A0,A1,A2,A3, then state=0.
REQ-037 SHALL cover: WRITE ch0 addr DEPTH-1 LEN 1 -> writes at DEPTH-1 then 0.
REQ-038 SHALL cover: command 0x43 with NUM_CH=3 -> err=1, no mem_we; then STATUS -> byte 0x83, and err=0 after it.
REQ-039 SHALL cover: spi_ss raised after 2 of 5 write bytes -> exactly 2 mem_we, state=0, busy=0.
REQ-040 SHALL cover: rst asserted in RDATA -> every output at its REQ-033 reset value on the next cycle.

Source files
------------

// File: rtl/spi_bram_bridge.sv
// SPI command decoder that streams bytes between an SPI slave and a multi-channel BRAM.
// Frame: command byte, address bytes (MSB first), 16-bit length, then LEN+1 data bytes.
module spi_bram_bridge #(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 76800,
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_ss,
    input  logic              spi_done,
    input  logic [7:0]        spi_rx,
    output logic [7:0]        spi_tx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CH_W-1:0]   mem_channel,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              err,
    output logic [2:0]        state
);

    localparam int AB = (ADDR_W + 7) / 8;
    localparam logic [2:0] NUM_CH_3 = 3'(NUM_CH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        STAT  = 3'd5
    } state_t;

    state_t            state_q;
    logic              ss_q;
    logic              armed;
    logic              is_read;
    logic              fetch1;
    logic              fetch2;
    logic [3:0]        byte_cnt;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] addr_sh;

    logic              ss_rise;
    logic              ss_fall;
    logic              ch_bad;
    logic              addr_bad;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_inc;
    logic [7:0]        status_byte;

    // Byte handshake is valid-only: spi_rx is meaningful exactly in the cycle spi_done
    // is high and the slave cannot be stalled, so every accepted byte is acted on at once.
    assign ss_rise     = ~ss_q & spi_ss;
    assign ss_fall     = ss_q & ~spi_ss;
    assign ch_bad      = 32'(spi_rx[CH_W-1:0]) >= NUM_CH;
    assign addr_next   = ADDR_W'({addr_sh, spi_rx});
    assign addr_bad    = 32'(addr_next) >= DEPTH;
    assign addr_inc    = (mem_addr == ADDR_W'(DEPTH - 1)) ? '0 : mem_addr + ADDR_W'(1);
    assign status_byte = {err, 1'b0, 3'b000, NUM_CH_3};

    assign busy  = (state_q != IDLE);
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ss_q        <= 1'b1;
            armed       <= 1'b0;
            is_read     <= 1'b0;
            fetch1      <= 1'b0;
            fetch2      <= 1'b0;
            byte_cnt    <= '0;
            cnt         <= '0;
            addr_sh     <= '0;
            err         <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_channel <= '0;
            mem_wdata   <= '0;
            spi_tx      <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            ss_q   <= spi_ss;
            fetch1 <= 1'b0;
            fetch2 <= fetch1;

            // Write address advances after the pulse so the pulse carries the current address.
            if (mem_we)
                mem_addr <= addr_inc;
            // BRAM data is valid one cycle after the address, so load on the second cycle.
            if (fetch2 && state_q == RDATA)
                spi_tx <= mem_rdata;
            if (ss_fall)
                armed <= 1'b1;

            if (ss_rise) begin
                state_q <= IDLE;
                armed   <= 1'b0;
                fetch1  <= 1'b0;
                fetch2  <= 1'b0;
                spi_tx  <= 8'h00;
            end else if (spi_done && !spi_ss) begin
                case (state_q)
                    IDLE: begin
                        if (armed) begin
                            armed    <= 1'b0;
                            byte_cnt <= '0;
                            cnt      <= '0;
                            addr_sh  <= '0;
                            case (spi_rx[7:6])
                                2'b01, 2'b10: begin
                                    if (ch_bad) begin
                                        err <= 1'b1;
                                    end else begin
                                        mem_channel <= spi_rx[CH_W-1:0];
                                        is_read     <= spi_rx[7];
                                        state_q     <= ADDR;
                                    end
                                end
                                2'b11: begin
                                    spi_tx  <= status_byte;
                                    state_q <= STAT;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ADDR: begin
                        addr_sh <= addr_next;
                        if (byte_cnt == 4'(AB - 1)) begin
                            byte_cnt <= '0;
                            if (addr_bad) begin
                                err     <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                mem_addr <= addr_next;
                                state_q  <= LEN;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                    LEN: begin
                        cnt <= {cnt[7:0], spi_rx};
                        if (byte_cnt == 4'd1) begin
                            byte_cnt <= '0;
                            state_q  <= is_read ? RDATA : WDATA;
                            fetch1   <= is_read;
                        end else begin
                            byte_cnt <= 4'd1;
                        end
                    end
                    WDATA: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= spi_rx;
                        if (cnt == 16'd0)
                            state_q <= IDLE;
                        else
                            cnt <= cnt - 16'd1;
                    end
                    RDATA: begin
                        if (cnt == 16'd0) begin
                            state_q <= IDLE;
                            spi_tx  <= 8'h00;
                        end else begin
                            cnt      <= cnt - 16'd1;
                            mem_addr <= addr_inc;
                            fetch1   <= 1'b1;
                        end
                    end
                    STAT: begin
                        err     <= 1'b0;
                        spi_tx  <= 8'h00;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
